// File: rtl/fp32_pkg.sv
// Shared constants, state and operand-class types for the FP32 multiplier back end.
package fp32_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 23;
    localparam int unsigned PROD_W = 2 * (MAN_W + 1);
    localparam int unsigned BIAS   = 127;
    localparam int unsigned E_W    = 10;

    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StWaitMul,
        StNorm,
        StRound,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        ClsNorm,
        ClsZero,
        ClsInf,
        ClsNan
    } op_class_e;

    // Denormals are flushed to zero, so any zero exponent is treated as zero.
    function automatic op_class_e classify(input logic [31:0] op);
        op_class_e cls;
        cls = ClsNorm;
        if (op[30:23] == '0) begin
            cls = ClsZero;
        end else if (op[30:23] == EXP_INF) begin
            cls = (op[22:0] == '0) ? ClsInf : ClsNan;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp32_mul_norm_round_if.sv
// Handshake and data bundle between the multiplier front end, back end and consumer.
interface fp32_mul_norm_round_if;
    import fp32_pkg::*;

    logic              start;
    logic [31:0]       op_a;
    logic [31:0]       op_b;
    logic              mul_ack;
    logic [PROD_W-1:0] mul_product;
    logic              mul_set_ack;
    logic              busy;
    logic [31:0]       result;
    logic              result_valid;
    logic              result_ack;
    logic              flag_ovf;
    logic              flag_unf;
    logic              flag_inv;

    modport slave (
        input  start, op_a, op_b, mul_ack, mul_product, result_ack,
        output mul_set_ack, busy, result, result_valid, flag_ovf, flag_unf, flag_inv
    );

    modport master (
        output start, op_a, op_b, mul_ack, mul_product, result_ack,
        input  mul_set_ack, busy, result, result_valid, flag_ovf, flag_unf, flag_inv
    );

endinterface

// File: rtl/fp32_mul_norm_round_rne.sv
// Round-to-nearest-even on a normalized 24-bit mantissa with exponent bump on carry out.
module fp_round_rne
    import fp32_pkg::*;
(
    input  logic [MAN_W:0] m,
    input  logic           g,
    input  logic           s,
    input  logic [E_W-1:0] e,
    output logic [MAN_W:0] m_rnd,
    output logic [E_W-1:0] e_rnd
);

    logic           round_up;
    logic [MAN_W+1:0] sum;

    assign round_up = g & (s | m[0]);
    assign sum      = {1'b0, m} + {{(MAN_W + 1){1'b0}}, round_up};

    always_comb begin
        m_rnd = sum[MAN_W:0];
        e_rnd = e;
        if (sum[MAN_W+1]) begin
            m_rnd = {1'b1, {MAN_W{1'b0}}};
            e_rnd = e + 10'd1;
        end
    end

endmodule

// File: rtl/fp32_mul_norm_round.sv
// FP32 multiplier back end: operand classing, product normalization, RNE rounding, packing.
module fp32_mul_norm_round
    import fp32_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    fp32_mul_norm_round_if.slave   bus
);

    state_e            state_q, state_d;
    logic              sign_q;
    logic [EXP_W-1:0]  ea_q, eb_q;
    op_class_e         cls_a_q, cls_b_q;
    logic [PROD_W-1:0] prod_q;
    logic [MAN_W:0]    m_q;
    logic              g_q, s_q;
    logic [E_W-1:0]    e_q;
    logic [31:0]       result_q;
    logic              valid_q, set_ack_q, ovf_q, unf_q, inv_q;

    logic [E_W-1:0]    e_sum;
    logic [MAN_W:0]    m_n;
    logic              g_n, s_n;
    logic [E_W-1:0]    e_n;
    logic [MAN_W:0]    m_r;
    logic [E_W-1:0]    e_r_raw;
    logic signed [E_W-1:0] e_r;
    logic              is_inv, any_inf, any_zero;
    logic [31:0]       res_c;
    logic              ovf_c, unf_c, inv_c;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (bus.start) state_d = StWaitMul;
            StWaitMul: if (bus.mul_ack) state_d = StNorm;
            StNorm:    state_d = StRound;
            StRound:   state_d = StDone;
            StDone:    if (valid_q && bus.result_ack) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    assign e_sum = {2'b00, ea_q} + {2'b00, eb_q} - 10'(BIAS);

    always_comb begin
        if (prod_q[PROD_W-1]) begin
            m_n = prod_q[47:24];
            g_n = prod_q[23];
            s_n = |prod_q[22:0];
            e_n = e_sum + 10'd1;
        end else begin
            m_n = prod_q[46:23];
            g_n = prod_q[22];
            s_n = |prod_q[21:0];
            e_n = e_sum;
        end
    end

    fp_round_rne u_round (
        .m     (m_q),
        .g     (g_q),
        .s     (s_q),
        .e     (e_q),
        .m_rnd (m_r),
        .e_rnd (e_r_raw)
    );

    assign e_r      = $signed(e_r_raw);
    assign is_inv   = (cls_a_q == ClsNan) || (cls_b_q == ClsNan) ||
                      (cls_a_q == ClsInf && cls_b_q == ClsZero) ||
                      (cls_a_q == ClsZero && cls_b_q == ClsInf);
    assign any_inf  = (cls_a_q == ClsInf) || (cls_b_q == ClsInf);
    assign any_zero = (cls_a_q == ClsZero) || (cls_b_q == ClsZero);

    always_comb begin
        res_c = {sign_q, e_r[7:0], m_r[MAN_W-1:0]};
        ovf_c = 1'b0;
        unf_c = 1'b0;
        inv_c = 1'b0;
        if (is_inv) begin
            res_c = QNAN;
            inv_c = 1'b1;
        end else if (any_inf) begin
            res_c = {sign_q, EXP_INF, {MAN_W{1'b0}}};
        end else if (any_zero) begin
            res_c = {sign_q, 31'b0};
        end else if (e_r >= 10'sd255) begin
            res_c = {sign_q, EXP_INF, {MAN_W{1'b0}}};
            ovf_c = 1'b1;
        end else if (e_r <= 10'sd0) begin
            res_c = {sign_q, 31'b0};
            unf_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            sign_q    <= 1'b0;
            ea_q      <= '0;
            eb_q      <= '0;
            cls_a_q   <= ClsNorm;
            cls_b_q   <= ClsNorm;
            prod_q    <= '0;
            m_q       <= '0;
            g_q       <= 1'b0;
            s_q       <= 1'b0;
            e_q       <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            set_ack_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            set_ack_q <= (state_q == StWaitMul) && bus.mul_ack;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        sign_q  <= bus.op_a[31] ^ bus.op_b[31];
                        ea_q    <= bus.op_a[30:23];
                        eb_q    <= bus.op_b[30:23];
                        cls_a_q <= classify(bus.op_a);
                        cls_b_q <= classify(bus.op_b);
                    end
                end
                StWaitMul: if (bus.mul_ack) prod_q <= bus.mul_product;
                StNorm: begin
                    m_q <= m_n;
                    g_q <= g_n;
                    s_q <= s_n;
                    e_q <= e_n;
                end
                StRound: begin
                    result_q <= res_c;
                    ovf_q    <= ovf_c;
                    unf_q    <= unf_c;
                    inv_q    <= inv_c;
                end
                StDone: begin
                    // Valid rises one cycle after entering DONE; ack is honoured only once it is up.
                    if (!valid_q) valid_q <= 1'b1;
                    else if (bus.result_ack) valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.mul_set_ack  = set_ack_q;
    assign bus.busy         = (state_q != StIdle);
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.flag_ovf     = ovf_q;
    assign bus.flag_unf     = unf_q;
    assign bus.flag_inv     = inv_q;

endmodule
